// File: rtl/segre_pkg.sv
// Shared sizes and types for the segre pipeline.
// Adds the MEM-stage FSM states and the base byte-enable patterns.
package segre_pkg;

  localparam int unsigned WORD_SIZE = 32;
  localparam int unsigned ADDR_SIZE = 32;
  localparam int unsigned REG_SIZE  = 5;

  typedef enum logic [1:0] {
    BYTE,
    HALF,
    WORD
  } memop_data_type_e;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT_R,
    DONE
  } mem_state_e;

  // Lane-0 patterns; BYTE and HALF are shifted left by the address offset.
  localparam logic [3:0] BE_BYTE = 4'b0001;
  localparam logic [3:0] BE_HALF = 4'b0011;
  localparam logic [3:0] BE_WORD = 4'b1111;

endpackage

// File: rtl/segre_mem_stage_if.sv
// Data-memory req/gnt/rvalid port between the MEM stage and the memory.
interface segre_mem_stage_if;
  import segre_pkg::*;

  logic                 req;
  logic                 we;
  logic [ADDR_SIZE-1:0] addr;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic                 gnt;
  logic                 rvalid;
  logic [WORD_SIZE-1:0] rdata;

  modport master (
    output req, we, addr, be, wdata,
    input  gnt, rvalid, rdata
  );

  modport slave (
    input  req, we, addr, be, wdata,
    output gnt, rvalid, rdata
  );

endinterface

// File: rtl/segre_mem_align.sv
// Store lane/byte-enable formation and load extract/extend.
// Purely combinational.
module segre_mem_align
  import segre_pkg::*;
(
  input  memop_data_type_e     memop_type_i,
  input  logic [1:0]           addr_lsb_i,
  input  logic [WORD_SIZE-1:0] st_data_i,
  input  logic [WORD_SIZE-1:0] rdata_i,
  input  logic                 sign_ext_i,
  output logic [3:0]           be_o,
  output logic [WORD_SIZE-1:0] wdata_o,
  output logic [WORD_SIZE-1:0] ld_data_o,
  output logic                 misaligned_o
);

  logic [7:0]  lane_byte;
  logic [15:0] lane_half;

  always_comb begin
    lane_byte    = rdata_i[{addr_lsb_i, 3'b000} +: 8];
    lane_half    = rdata_i[{addr_lsb_i[1], 4'b0000} +: 16];
    be_o         = BE_WORD;
    wdata_o      = st_data_i;
    ld_data_o    = rdata_i;
    misaligned_o = 1'b0;
    unique case (memop_type_i)
      BYTE: begin
        be_o      = BE_BYTE << addr_lsb_i;
        wdata_o   = {4{st_data_i[7:0]}};
        ld_data_o = {{(WORD_SIZE-8){sign_ext_i & lane_byte[7]}}, lane_byte};
      end
      HALF: begin
        be_o         = BE_HALF << addr_lsb_i;
        wdata_o      = {2{st_data_i[15:0]}};
        ld_data_o    = {{(WORD_SIZE-16){sign_ext_i & lane_half[15]}}, lane_half};
        misaligned_o = addr_lsb_i[0];
      end
      default: begin
        misaligned_o = |addr_lsb_i;
      end
    endcase
  end

endmodule

// File: rtl/segre_mem_stage.sv
// MEM stage: registers EX results, runs loads/stores over the req/gnt/rvalid port,
// and presents the writeback value to WB, stalling upstream while an access is open.
module segre_mem_stage
  import segre_pkg::*;
(
  input  logic                 clk_i,
  input  logic                 rsn_i,
  input  logic                 valid_ex_i,
  input  logic [WORD_SIZE-1:0] alu_res_i,
  input  logic                 rf_we_i,
  input  logic [REG_SIZE-1:0]  rf_waddr_i,
  input  logic [WORD_SIZE-1:0] rf_st_data_i,
  input  memop_data_type_e     memop_type_i,
  input  logic                 memop_rd_i,
  input  logic                 memop_wr_i,
  input  logic                 memop_sign_ext_i,
  input  logic [ADDR_SIZE-1:0] seq_new_pc_i,
  input  logic                 is_jaljalr_i,
  input  logic                 block_mem_i,
  input  logic                 inject_nops_i,
  segre_mem_stage_if.master    mem_if,
  output logic                 rf_we_o,
  output logic [REG_SIZE-1:0]  rf_waddr_o,
  output logic [WORD_SIZE-1:0] rf_wdata_o,
  output logic                 valid_mem_o,
  output logic                 mem_busy_o,
  output logic                 misaligned_o
);

  logic                 valid_q;
  logic [WORD_SIZE-1:0] alu_res_q;
  logic                 rf_we_q;
  logic [REG_SIZE-1:0]  rf_waddr_q;
  logic [WORD_SIZE-1:0] st_data_q;
  memop_data_type_e     memop_type_q;
  logic                 rd_q;
  logic                 wr_q;
  logic                 sign_ext_q;
  logic [ADDR_SIZE-1:0] seq_pc_q;
  logic                 is_jal_q;

  mem_state_e           state_q;
  logic [WORD_SIZE-1:0] ld_data_q;

  logic                 mem_op;
  logic                 misaligned;
  logic                 req;
  logic [3:0]           be;
  logic [WORD_SIZE-1:0] wdata;
  logic [WORD_SIZE-1:0] ld_ext;

  assign mem_op     = valid_q & (rd_q | wr_q);
  assign mem_busy_o = mem_op & (state_q != DONE);

  segre_mem_align u_align (
    .memop_type_i (memop_type_q),
    .addr_lsb_i   (alu_res_q[1:0]),
    .st_data_i    (st_data_q),
    .rdata_i      (mem_if.rdata),
    .sign_ext_i   (sign_ext_q),
    .be_o         (be),
    .wdata_o      (wdata),
    .ld_data_o    (ld_ext),
    .misaligned_o (misaligned)
  );

  // Stage register: held while blocked or while a memory access is still open.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      valid_q      <= 1'b0;
      alu_res_q    <= '0;
      rf_we_q      <= 1'b0;
      rf_waddr_q   <= '0;
      st_data_q    <= '0;
      memop_type_q <= BYTE;
      rd_q         <= 1'b0;
      wr_q         <= 1'b0;
      sign_ext_q   <= 1'b0;
      seq_pc_q     <= '0;
      is_jal_q     <= 1'b0;
    end else if (!block_mem_i && !mem_busy_o) begin
      if (inject_nops_i) begin
        valid_q <= 1'b0;
        rf_we_q <= 1'b0;
        rd_q    <= 1'b0;
        wr_q    <= 1'b0;
      end else begin
        valid_q      <= valid_ex_i;
        alu_res_q    <= alu_res_i;
        rf_we_q      <= rf_we_i;
        rf_waddr_q   <= rf_waddr_i;
        st_data_q    <= rf_st_data_i;
        memop_type_q <= memop_type_i;
        rd_q         <= memop_rd_i;
        wr_q         <= memop_wr_i;
        sign_ext_q   <= memop_sign_ext_i;
        seq_pc_q     <= seq_new_pc_i;
        is_jal_q     <= is_jaljalr_i;
      end
    end
  end

  // rvalid is only consumed in WAIT_R, so a stray response can never complete an access.
  always_ff @(posedge clk_i) begin
    if (!rsn_i) begin
      state_q   <= IDLE;
      ld_data_q <= '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (mem_op) begin
            if (misaligned)      state_q <= DONE;
            else if (mem_if.gnt) state_q <= wr_q ? DONE : WAIT_R;
            else                 state_q <= REQ;
          end
        end
        REQ: begin
          if (mem_if.gnt) state_q <= wr_q ? DONE : WAIT_R;
        end
        WAIT_R: begin
          if (mem_if.rvalid) begin
            ld_data_q <= ld_ext;
            state_q   <= DONE;
          end
        end
        DONE: begin
          if (!block_mem_i) state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req          = ((state_q == IDLE) & mem_op & ~misaligned) | (state_q == REQ);
  assign misaligned_o = (state_q == IDLE) & mem_op & misaligned;

  assign mem_if.req   = req;
  assign mem_if.we    = req & wr_q;
  assign mem_if.addr  = req ? {alu_res_q[ADDR_SIZE-1:2], 2'b00} : '0;
  assign mem_if.be    = req ? be : 4'b0000;
  assign mem_if.wdata = req ? wdata : '0;

  assign rf_waddr_o = rf_waddr_q;

  always_comb begin
    valid_mem_o = 1'b0;
    rf_we_o     = 1'b0;
    rf_wdata_o  = '0;
    if (state_q == DONE) begin
      valid_mem_o = 1'b1;
      rf_we_o     = rf_we_q & rd_q & ~wr_q & ~misaligned;
      rf_wdata_o  = ld_data_q;
    end else if (valid_q && !mem_op) begin
      valid_mem_o = 1'b1;
      rf_we_o     = rf_we_q;
      rf_wdata_o  = is_jal_q ? seq_pc_q : alu_res_q;
    end
  end

endmodule

// File: tb/tb_segre_mem_stage.sv
// Directed bench for segre_mem_stage: ALU, loads, stores, misalignment, reset, block, bubbles.
module tb_segre_mem_stage;
  import segre_pkg::*;

  logic             clk = 1'b0;
  logic             rsn_i;
  logic             valid_ex_i;
  logic [31:0]      alu_res_i;
  logic             rf_we_i;
  logic [4:0]       rf_waddr_i;
  logic [31:0]      rf_st_data_i;
  memop_data_type_e memop_type_i;
  logic             memop_rd_i;
  logic             memop_wr_i;
  logic             memop_sign_ext_i;
  logic [31:0]      seq_new_pc_i;
  logic             is_jaljalr_i;
  logic             block_mem_i;
  logic             inject_nops_i;
  logic             rf_we_o;
  logic [4:0]       rf_waddr_o;
  logic [31:0]      rf_wdata_o;
  logic             valid_mem_o;
  logic             mem_busy_o;
  logic             misaligned_o;

  int total = 0;
  int bad   = 0;

  segre_mem_stage_if mem_if ();

  always #5 clk = ~clk;

  segre_mem_stage dut (
    .clk_i            (clk),
    .rsn_i            (rsn_i),
    .valid_ex_i       (valid_ex_i),
    .alu_res_i        (alu_res_i),
    .rf_we_i          (rf_we_i),
    .rf_waddr_i       (rf_waddr_i),
    .rf_st_data_i     (rf_st_data_i),
    .memop_type_i     (memop_type_i),
    .memop_rd_i       (memop_rd_i),
    .memop_wr_i       (memop_wr_i),
    .memop_sign_ext_i (memop_sign_ext_i),
    .seq_new_pc_i     (seq_new_pc_i),
    .is_jaljalr_i     (is_jaljalr_i),
    .block_mem_i      (block_mem_i),
    .inject_nops_i    (inject_nops_i),
    .mem_if           (mem_if),
    .rf_we_o          (rf_we_o),
    .rf_waddr_o       (rf_waddr_o),
    .rf_wdata_o       (rf_wdata_o),
    .valid_mem_o      (valid_mem_o),
    .mem_busy_o       (mem_busy_o),
    .misaligned_o     (misaligned_o)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_ex();
    valid_ex_i       = 1'b0;
    alu_res_i        = '0;
    rf_we_i          = 1'b0;
    rf_waddr_i       = '0;
    rf_st_data_i     = '0;
    memop_type_i     = BYTE;
    memop_rd_i       = 1'b0;
    memop_wr_i       = 1'b0;
    memop_sign_ext_i = 1'b0;
    seq_new_pc_i     = '0;
    is_jaljalr_i     = 1'b0;
  endtask

  task automatic alu_op(input logic [31:0] res, input logic [4:0] rd);
    clear_ex();
    valid_ex_i = 1'b1;
    alu_res_i  = res;
    rf_we_i    = 1'b1;
    rf_waddr_i = rd;
  endtask

  task automatic test_reset();
    rsn_i = 1'b0;
    clear_ex();
    block_mem_i = 1'b0;
    inject_nops_i = 1'b0;
    mem_if.gnt = 1'b0;
    mem_if.rvalid = 1'b0;
    mem_if.rdata = '0;
    step();
    step();
    total++;
    if ({mem_if.req, valid_mem_o, rf_we_o, mem_busy_o, misaligned_o} !== 5'b0) begin
      bad++;
      $display("FAIL reset_ctrl got=%b want=00000",
               {mem_if.req, valid_mem_o, rf_we_o, mem_busy_o, misaligned_o});
    end
    total++;
    if ({rf_wdata_o, rf_waddr_o} !== 37'h0) begin
      bad++;
      $display("FAIL reset_wb got=%h/%0d want=0/0", rf_wdata_o, rf_waddr_o);
    end
    total++;
    if ({mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata} !== 69'h0) begin
      bad++;
      $display("FAIL reset_bus got we=%b addr=%h be=%b wdata=%h want zeros",
               mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata);
    end
    rsn_i = 1'b1;
    step();
  endtask

  task automatic test_alu();
    alu_op(32'h1234, 5'd5);
    step();
    clear_ex();
    total++;
    if ({valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 1'b1, 5'd5, 32'h1234}) begin
      bad++;
      $display("FAIL alu_wb got v=%b we=%b rd=%0d d=%h want 1 1 5 00001234",
               valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    total++;
    if ({mem_busy_o, mem_if.req} !== 2'b00) begin
      bad++;
      $display("FAIL alu_nostall got busy=%b req=%b want 0 0", mem_busy_o, mem_if.req);
    end
    step();
    total++;
    if (valid_mem_o !== 1'b0) begin
      bad++;
      $display("FAIL alu_once got valid=%b want 0", valid_mem_o);
    end
  endtask

  task automatic test_load_byte();
    clear_ex();
    valid_ex_i = 1'b1; alu_res_i = 32'h103; rf_we_i = 1'b1; rf_waddr_i = 5'd7;
    memop_type_i = BYTE; memop_rd_i = 1'b1; memop_sign_ext_i = 1'b1;
    step();
    alu_op(32'h55, 5'd3);  // next instruction waits in EX while the load is open
    mem_if.gnt = 1'b1;
    total++;
    if ({mem_if.req, mem_if.we, mem_if.addr, mem_busy_o, valid_mem_o} !==
        {1'b1, 1'b0, 32'h100, 1'b1, 1'b0}) begin
      bad++;
      $display("FAIL lb_req got req=%b we=%b addr=%h busy=%b v=%b want 1 0 00000100 1 0",
               mem_if.req, mem_if.we, mem_if.addr, mem_busy_o, valid_mem_o);
    end
    step();
    mem_if.gnt = 1'b0;
    total++;
    if ({mem_if.req, mem_busy_o, valid_mem_o, rf_we_o} !== 4'b0100) begin
      bad++;
      $display("FAIL lb_wait got req=%b busy=%b v=%b we=%b want 0 1 0 0",
               mem_if.req, mem_busy_o, valid_mem_o, rf_we_o);
    end
    mem_if.rvalid = 1'b1;
    mem_if.rdata = 32'h80AABBCC;
    step();
    mem_if.rvalid = 1'b0;
    total++;
    if ({mem_busy_o, valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o} !==
        {1'b0, 1'b1, 1'b1, 5'd7, 32'hFFFFFF80}) begin
      bad++;
      $display("FAIL lb_done got busy=%b v=%b we=%b rd=%0d d=%h want 0 1 1 7 ffffff80",
               mem_busy_o, valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    step();
    clear_ex();
    total++;
    if ({valid_mem_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd3, 32'h55}) begin
      bad++;
      $display("FAIL lb_next got v=%b rd=%0d d=%h want 1 3 00000055",
               valid_mem_o, rf_waddr_o, rf_wdata_o);
    end
    step();
  endtask

  task automatic test_load_half_gnt_rvalid();
    clear_ex();
    valid_ex_i = 1'b1; alu_res_i = 32'h202; rf_we_i = 1'b1; rf_waddr_i = 5'd9;
    memop_type_i = HALF; memop_rd_i = 1'b1;
    step();
    clear_ex();
    mem_if.gnt = 1'b1;
    mem_if.rvalid = 1'b1;  // must be ignored: no access outstanding yet
    mem_if.rdata = 32'hFFFFFFFF;
    step();
    mem_if.gnt = 1'b0;
    total++;
    if ({mem_busy_o, mem_if.req, valid_mem_o} !== 3'b100) begin
      bad++;
      $display("FAIL lhu_wait got busy=%b req=%b v=%b want 1 0 0",
               mem_busy_o, mem_if.req, valid_mem_o);
    end
    mem_if.rdata = 32'h80AABBCC;
    step();
    mem_if.rvalid = 1'b0;
    total++;
    if ({valid_mem_o, rf_we_o, rf_wdata_o} !== {1'b1, 1'b1, 32'h000080AA}) begin
      bad++;
      $display("FAIL lhu_done got v=%b we=%b d=%h want 1 1 000080aa",
               valid_mem_o, rf_we_o, rf_wdata_o);
    end
    step();
  endtask

  task automatic test_store_half();
    clear_ex();
    valid_ex_i = 1'b1; alu_res_i = 32'h102; rf_st_data_i = 32'h0000BEEF;
    rf_we_i = 1'b1; rf_waddr_i = 5'd4; memop_type_i = HALF; memop_wr_i = 1'b1;
    step();
    alu_op(32'h77, 5'd6);
    inject_nops_i = 1'b1;  // ignored while busy
    for (int i = 0; i < 4; i++) begin
      total++;
      if ({mem_if.req, mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata, mem_busy_o} !==
          {1'b1, 1'b1, 32'h100, 4'b1100, 32'hBEEFBEEF, 1'b1}) begin
        bad++;
        $display("FAIL sh_req%0d got req=%b we=%b addr=%h be=%b wd=%h busy=%b", i,
                 mem_if.req, mem_if.we, mem_if.addr, mem_if.be, mem_if.wdata, mem_busy_o);
      end
      mem_if.gnt = (i == 3);
      if (i == 3) inject_nops_i = 1'b0;
      step();
    end
    mem_if.gnt = 1'b0;
    total++;
    if ({valid_mem_o, rf_we_o, mem_busy_o, mem_if.req} !== 4'b1000) begin
      bad++;
      $display("FAIL sh_done got v=%b we=%b busy=%b req=%b want 1 0 0 0",
               valid_mem_o, rf_we_o, mem_busy_o, mem_if.req);
    end
    block_mem_i = 1'b1;
    step();
    total++;
    if ({valid_mem_o, rf_we_o, rf_waddr_o, mem_if.req} !== {1'b1, 1'b0, 5'd4, 1'b0}) begin
      bad++;
      $display("FAIL sh_block got v=%b we=%b rd=%0d req=%b want 1 0 4 0",
               valid_mem_o, rf_we_o, rf_waddr_o, mem_if.req);
    end
    block_mem_i = 1'b0;
    step();
    clear_ex();
    total++;
    if ({valid_mem_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 5'd6, 32'h77}) begin
      bad++;
      $display("FAIL sh_next got v=%b rd=%0d d=%h want 1 6 00000077",
               valid_mem_o, rf_waddr_o, rf_wdata_o);
    end
    step();
  endtask

  task automatic test_misaligned();
    clear_ex();
    valid_ex_i = 1'b1; alu_res_i = 32'h201; rf_we_i = 1'b1; rf_waddr_i = 5'd2;
    memop_type_i = WORD; memop_rd_i = 1'b1;
    step();
    clear_ex();
    mem_if.gnt = 1'b1;  // a grant must not matter: nothing is requested
    total++;
    if ({mem_if.req, misaligned_o, mem_busy_o, valid_mem_o} !== 4'b0110) begin
      bad++;
      $display("FAIL lw_mis got req=%b mis=%b busy=%b v=%b want 0 1 1 0",
               mem_if.req, misaligned_o, mem_busy_o, valid_mem_o);
    end
    step();
    mem_if.gnt = 1'b0;
    total++;
    if ({valid_mem_o, rf_we_o, misaligned_o, mem_busy_o} !== 4'b1000) begin
      bad++;
      $display("FAIL lw_mis_done got v=%b we=%b mis=%b busy=%b want 1 0 0 0",
               valid_mem_o, rf_we_o, misaligned_o, mem_busy_o);
    end
    step();
  endtask

  task automatic test_reset_mid();
    clear_ex();
    valid_ex_i = 1'b1; alu_res_i = 32'h200; rf_we_i = 1'b1; rf_waddr_i = 5'd8;
    memop_type_i = WORD; memop_rd_i = 1'b1;
    step();
    clear_ex();
    mem_if.gnt = 1'b1;
    step();
    mem_if.gnt = 1'b0;
    total++;
    if ({mem_busy_o, mem_if.req} !== 2'b10) begin
      bad++;
      $display("FAIL rst_mid_wait got busy=%b req=%b want 1 0", mem_busy_o, mem_if.req);
    end
    rsn_i = 1'b0;
    step();
    rsn_i = 1'b1;
    total++;
    if ({mem_if.req, valid_mem_o, rf_we_o, mem_busy_o, rf_waddr_o, rf_wdata_o} !== 41'h0) begin
      bad++;
      $display("FAIL rst_mid got req=%b v=%b we=%b busy=%b rd=%0d d=%h want zeros",
               mem_if.req, valid_mem_o, rf_we_o, mem_busy_o, rf_waddr_o, rf_wdata_o);
    end
    mem_if.rvalid = 1'b1;
    mem_if.rdata = 32'h12345678;
    step();
    mem_if.rvalid = 1'b0;
    total++;
    if ({valid_mem_o, rf_we_o, mem_busy_o, rf_wdata_o} !== 35'h0) begin
      bad++;
      $display("FAIL rst_stray got v=%b we=%b busy=%b d=%h want 0 0 0 0",
               valid_mem_o, rf_we_o, mem_busy_o, rf_wdata_o);
    end
    step();
  endtask

  task automatic test_block_jal();
    clear_ex();
    valid_ex_i = 1'b1; is_jaljalr_i = 1'b1; seq_new_pc_i = 32'h48; alu_res_i = 32'h999;
    rf_we_i = 1'b1; rf_waddr_i = 5'd1;
    block_mem_i = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step();
      total++;
      if (valid_mem_o !== 1'b0) begin
        bad++;
        $display("FAIL jal_block%0d got v=%b want 0", i, valid_mem_o);
      end
    end
    block_mem_i = 1'b0;
    step();
    clear_ex();
    total++;
    if ({valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o} !== {1'b1, 1'b1, 5'd1, 32'h48}) begin
      bad++;
      $display("FAIL jal_wb got v=%b we=%b rd=%0d d=%h want 1 1 1 00000048",
               valid_mem_o, rf_we_o, rf_waddr_o, rf_wdata_o);
    end
    step();
    total++;
    if (valid_mem_o !== 1'b0) begin
      bad++;
      $display("FAIL jal_dup got v=%b want 0", valid_mem_o);
    end
  endtask

  task automatic test_inject();
    alu_op(32'hCAFE, 5'd11);
    inject_nops_i = 1'b1;
    step();
    total++;
    if ({valid_mem_o, rf_we_o} !== 2'b00) begin
      bad++;
      $display("FAIL inject_bubble got v=%b we=%b want 0 0", valid_mem_o, rf_we_o);
    end
    inject_nops_i = 1'b0;
    step();
    clear_ex();
    total++;
    if ({valid_mem_o, rf_wdata_o} !== {1'b1, 32'hCAFE}) begin
      bad++;
      $display("FAIL inject_release got v=%b d=%h want 1 0000cafe", valid_mem_o, rf_wdata_o);
    end
    step();
  endtask

  initial begin
    test_reset();
    test_alu();
    test_load_byte();
    test_load_half_gnt_rvalid();
    test_store_half();
    test_misaligned();
    test_reset_mid();
    test_block_jal();
    test_inject();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
